lfsr_checker: RTL

//  Receive-side companion to the lfsr generator. Consumes a stream of LFSR words
//  and self-synchronises to it. Once locked, it predicts every following word and

---
 rtl/lfsr_checker.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: self-synchronises to an incoming LFSR word stream,
// then flywheels its own prediction and flags/counts mismatches while locked.
module lfsr_checker #(
  parameter int               WIDTH       = 3,
  parameter logic [WIDTH-1:0] TAPS        = 'h6,
  parameter int               LOCK_COUNT  = 4,
  parameter int               UNLOCK_ERRS = 4,
  parameter int               ERR_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 err_clr,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [1:0]           state_o
);

  localparam int RUN_MAX = (LOCK_COUNT > UNLOCK_ERRS) ? LOCK_COUNT : UNLOCK_ERRS;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);
  localparam logic [RUN_W-1:0] LOCK_RUN   = RUN_W'(LOCK_COUNT);
  localparam logic [RUN_W-1:0] UNLOCK_RUN = RUN_W'(UNLOCK_ERRS);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], ^(x & TAPS)};
  endfunction

  state_t                r_state;
  logic [WIDTH-1:0]      r_predict;
  logic [RUN_W-1:0]      r_good_run;
  logic [RUN_W-1:0]      r_bad_run;
  logic                  r_locked;
  logic                  r_err_pulse;
  logic [ERR_CNT_W-1:0]  r_err_count;

  state_t                w_state_nxt;
  logic [WIDTH-1:0]      w_predict_nxt;
  logic [RUN_W-1:0]      w_good_nxt;
  logic [RUN_W-1:0]      w_bad_nxt;
  logic                  w_locked_nxt;
  logic                  w_pulse_nxt;
  logic                  w_err_inc;
  logic [ERR_CNT_W-1:0]  w_err_nxt;

  logic                  w_word_nz;
  logic                  w_match;
  logic [RUN_W-1:0]      w_good_inc;
  logic [RUN_W-1:0]      w_bad_inc;

  assign w_word_nz  = |in_data;
  assign w_match    = (in_data == r_predict);
  assign w_good_inc = r_good_run + RUN_W'(1);
  assign w_bad_inc  = r_bad_run + RUN_W'(1);

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    w_state_nxt   = r_state;
    w_predict_nxt = r_predict;
    w_good_nxt    = r_good_run;
    w_bad_nxt     = r_bad_run;
    w_locked_nxt  = r_locked;
    w_pulse_nxt   = 1'b0;
    w_err_inc     = 1'b0;

    if (in_valid) begin
      unique case (r_state)
        ST_SEARCH: begin
          // All-zero is the LFSR lockup word and cannot seed a prediction.
          if (w_word_nz) begin
            w_predict_nxt = lfsr_next(in_data);
            w_good_nxt    = '0;
            w_state_nxt   = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (w_match) begin
            w_predict_nxt = lfsr_next(in_data);
            w_good_nxt    = w_good_inc;
            if (w_good_inc == LOCK_RUN) begin
              w_state_nxt  = ST_LOCKED;
              w_locked_nxt = 1'b1;
              w_bad_nxt    = '0;
            end
          end else if (w_word_nz) begin
            w_predict_nxt = lfsr_next(in_data);
            w_good_nxt    = '0;
          end else begin
            w_state_nxt = ST_SEARCH;
          end
        end
        ST_LOCKED: begin
          // Flywheel: the received word never re-seeds once locked.
          w_predict_nxt = lfsr_next(r_predict);
          if (w_match) begin
            w_bad_nxt = '0;
          end else begin
            w_pulse_nxt = 1'b1;
            w_err_inc   = 1'b1;
            w_bad_nxt   = w_bad_inc;
            if (w_bad_inc == UNLOCK_RUN) begin
              w_state_nxt  = ST_SEARCH;
              w_locked_nxt = 1'b0;
            end
          end
        end
        default: begin
          w_state_nxt  = ST_SEARCH;
          w_locked_nxt = 1'b0;
        end
      endcase
    end

    if (err_clr) begin
      w_err_nxt = '0;
    end else if (w_err_inc && !(&r_err_count)) begin
      w_err_nxt = r_err_count + ERR_CNT_W'(1);
    end else begin
      w_err_nxt = r_err_count;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_SEARCH;
      r_predict   <= '0;
      r_good_run  <= '0;
      r_bad_run   <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_predict   <= w_predict_nxt;
      r_good_run  <= w_good_nxt;
      r_bad_run   <= w_bad_nxt;
      r_locked    <= w_locked_nxt;
      r_err_pulse <= w_pulse_nxt;
      r_err_count <= w_err_nxt;
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;
  assign state_o   = r_state;

endmodule
